rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
- Upstream pixel producer for the 320x240x8 framebuffer stage.
- Takes a filled-rectangle command (origin, size, colour) or a full-screen clear request.
- Emits one framebuffer write per clock, in row-major order, clipped to the visible area.
- Write coordinates are in the framebuffer's 640x480 input space (logical coordinate << 1), because the framebuffer halves its write coordinates.

Parameters:
- H_RES, 320, logical width in pixels
- V_RES, 240, logical height in pixels
- COORD_W, 11, width of all coordinate and size fields
- COLOR_W, 8, pixel width
- CLEAR_COLOR, 255, colour written by a clear request

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  command strobe; sampled only in IDLE
- clear  in  1  full-screen clear strobe; sampled only in IDLE; priority over start
- rect_x  in  COORD_W  logical left column
- rect_y  in  COORD_W  logical top row
- rect_w  in  COORD_W  width in pixels
- rect_h  in  COORD_W  height in pixels
- color  in  COLOR_W  fill colour
- wr_en  out  1  framebuffer write enable
- wr_x  out  COORD_W  write column, equal to logical x << 1
- wr_y  out  COORD_W  write row, equal to logical y << 1
- wr_data  out  COLOR_W  write pixel
- busy  out  1  high while writes are in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values: wr_en=0, wr_x=0, wr_y=0, wr_data=0, busy=0, done=0, state=IDLE.
- All outputs are registered.
- States: IDLE, FILL.
- Clipping, evaluated in IDLE at the sampling edge using COORD_W+1-bit arithmetic:
  - x_end = min(rect_x+rect_w, H_RES)
  - y_end = min(rect_y+rect_h, V_RES)
  - The command is empty if rect_w==0, rect_h==0, rect_x>=H_RES or rect_y>=V_RES.
- clear behaves as a command with x=0, y=0, w=H_RES, h=V_RES, colour=CLEAR_COLOR. When clear and start are high together, clear wins and start is dropped.
- IDLE, edge with start or clear high, non-empty command:
  - Capture parameters and go to FILL.
  - busy<=1, wr_en<=1, wr_x<=rect_x<<1, wr_y<=rect_y<<1, wr_data<=colour.
  - The first write is therefore visible in the cycle immediately after the sampling edge.
- IDLE, edge with an empty command: stay in IDLE, done<=1 for one cycle, no wr_en.
- FILL, each edge:
  - Advance the logical x by 1.
  - When x+1==x_end, x returns to rect_x and y advances by 1.
  - After the pixel (x_end-1, y_end-1) has been presented: wr_en<=0, busy<=0, done<=1, go to IDLE.
  - Total write cycles = (x_end-rect_x)*(y_end-rect_y), with no gaps.
- done lasts exactly one cycle. A new command may be sampled on the same edge on which done is deasserted.
- start and clear are ignored while busy; the captured colour and geometry are immune to input changes during FILL.
- wr_x and wr_y hold their last values when wr_en=0. wr_data is don't-care when wr_en=0.
- Reset asserted mid-FILL: outputs take their reset values immediately, no done pulse is produced, and the remaining pixels are abandoned.

Test Plan:
- Basic fill: reset, then start with x=10, y=5, w=2, h=2, color=0x3C.
  - Writes (20,10), (22,10), (20,12), (22,12) with data 0x3C on 4 consecutive cycles starting 1 cycle after the start edge.
  - busy is high for those 4 cycles; done pulses on cycle 5.
- Clipping: start with x=318, y=239, w=5, h=3.
  - Exactly 2 writes: (636,478) and (638,478).
  - done follows on the next cycle.
- Empty and off-screen commands: w=0; then x=320.
  - Each produces no wr_en and a done pulse 1 cycle after the start edge.
- Clear with priority: clear=1 and start=1 on the same edge.
  - 76800 writes of 0xFF, first (0,0), last (638,478), row-major.
  - A reference-model scoreboard compares every write; the rectangle carried by start is never written.
- Busy protection: a start pulse with different colour and geometry mid-fill.
  - The write stream is unchanged and no second done pulse appears.
- Async reset: assert reset after 3 writes of a 4x4 fill, between clock edges.
  - wr_en, busy and done drop to 0 without waiting for a clock edge.
  - After release, a new 1x1 command writes exactly 1 pixel.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Filled-rectangle / full-screen clear pixel producer for the 320x240 framebuffer.
// Emits one registered write per clock in row-major order, in the framebuffer's 2x write space.
module rect_fill_engine #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int COORD_W     = 11,
    parameter int COLOR_W     = 8,
    parameter int CLEAR_COLOR = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic [COORD_W-1:0] rect_x,
    input  logic [COORD_W-1:0] rect_y,
    input  logic [COORD_W-1:0] rect_w,
    input  logic [COORD_W-1:0] rect_h,
    input  logic [COLOR_W-1:0] color,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               state
);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    localparam logic [COORD_W:0]   H_LIM   = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0]   V_LIM   = (COORD_W+1)'(V_RES);
    localparam logic [COORD_W:0]   ONE_EXT = (COORD_W+1)'(1);
    localparam logic [COLOR_W-1:0] CLR_COL = COLOR_W'(CLEAR_COLOR);

    state_t             state_q, state_next;
    logic [COORD_W-1:0] x_q, x_next;
    logic [COORD_W-1:0] y_q, y_next;
    logic [COORD_W-1:0] x_start_q, x_start_next;
    logic [COORD_W:0]   x_end_q, x_end_next;
    logic [COORD_W:0]   y_end_q, y_end_next;
    logic [COLOR_W-1:0] color_q, color_next;
    logic               wr_en_next, busy_next, done_next;
    logic [COORD_W-1:0] wr_x_next, wr_y_next;
    logic [COLOR_W-1:0] wr_data_next;

    // Command as seen in IDLE: clear overrides whatever start carries
    logic [COORD_W-1:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic [COORD_W:0]   sum_x, sum_y, cmd_x_end, cmd_y_end;
    logic               cmd_empty, cmd_strobe;
    logic [COORD_W:0]   x_inc, y_inc;
    logic               last_col, last_row;

    always_comb begin
        if (clear) begin
            cmd_x     = '0;
            cmd_y     = '0;
            cmd_w     = COORD_W'(H_RES);
            cmd_h     = COORD_W'(V_RES);
            cmd_color = CLR_COL;
        end else begin
            cmd_x     = rect_x;
            cmd_y     = rect_y;
            cmd_w     = rect_w;
            cmd_h     = rect_h;
            cmd_color = color;
        end
        cmd_strobe = start | clear;
        sum_x      = {1'b0, cmd_x} + {1'b0, cmd_w};
        sum_y      = {1'b0, cmd_y} + {1'b0, cmd_h};
        cmd_x_end  = (sum_x > H_LIM) ? H_LIM : sum_x;
        cmd_y_end  = (sum_y > V_LIM) ? V_LIM : sum_y;
        cmd_empty  = (cmd_w == '0) || (cmd_h == '0) ||
                     ({1'b0, cmd_x} >= H_LIM) || ({1'b0, cmd_y} >= V_LIM);
        x_inc      = {1'b0, x_q} + ONE_EXT;
        y_inc      = {1'b0, y_q} + ONE_EXT;
        last_col   = (x_inc == x_end_q);
        last_row   = (y_inc == y_end_q);
    end

    always_comb begin
        state_next   = state_q;
        x_next       = x_q;
        y_next       = y_q;
        x_start_next = x_start_q;
        x_end_next   = x_end_q;
        y_end_next   = y_end_q;
        color_next   = color_q;
        wr_en_next   = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        wr_x_next    = wr_x;
        wr_y_next    = wr_y;
        wr_data_next = wr_data;

        case (state_q)
            IDLE: begin
                if (cmd_strobe) begin
                    if (cmd_empty) begin
                        done_next = 1'b1;
                    end else begin
                        state_next   = FILL;
                        x_next       = cmd_x;
                        y_next       = cmd_y;
                        x_start_next = cmd_x;
                        x_end_next   = cmd_x_end;
                        y_end_next   = cmd_y_end;
                        color_next   = cmd_color;
                        wr_en_next   = 1'b1;
                        busy_next    = 1'b1;
                        wr_x_next    = {cmd_x[COORD_W-2:0], 1'b0};
                        wr_y_next    = {cmd_y[COORD_W-2:0], 1'b0};
                        wr_data_next = cmd_color;
                    end
                end
            end
            FILL: begin
                // x_q/y_q is the pixel currently presented on the write port
                if (last_col && last_row) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    if (last_col) begin
                        x_next = x_start_q;
                        y_next = y_inc[COORD_W-1:0];
                    end else begin
                        x_next = x_inc[COORD_W-1:0];
                    end
                    wr_en_next   = 1'b1;
                    busy_next    = 1'b1;
                    wr_x_next    = {x_next[COORD_W-2:0], 1'b0};
                    wr_y_next    = {y_next[COORD_W-2:0], 1'b0};
                    wr_data_next = color_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            color_q   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_x      <= '0;
            wr_y      <= '0;
            wr_data   <= '0;
        end else begin
            state_q   <= state_next;
            x_q       <= x_next;
            y_q       <= y_next;
            x_start_q <= x_start_next;
            x_end_q   <= x_end_next;
            y_end_q   <= y_end_next;
            color_q   <= color_next;
            wr_en     <= wr_en_next;
            busy      <= busy_next;
            done      <= done_next;
            wr_x      <= wr_x_next;
            wr_y      <= wr_y_next;
            wr_data   <= wr_data_next;
        end
    end

    assign state = (state_q == FILL);

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed cases plus random rectangles, each write
// stream compared against a row-major model of the clipped rectangle.
module tb_rect_fill_engine;

    localparam int CW = 11;
    localparam int DW = 8;
    localparam int EW = CW + CW + DW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
    logic [DW-1:0] color = '0;
    logic          wr_en, busy, done, state;
    logic [CW-1:0] wr_x, wr_y;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    rect_fill_engine dut (
        .clock(clock), .reset(reset), .start(start), .clear(clear),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .color(color), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .busy(busy), .done(done), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference: every visible pixel of the clipped rectangle, row by row
    task automatic model(input int x, input int y, input int w, input int h, input int col);
        int xe, ye;
        exp_q.delete();
        if (w == 0 || h == 0 || x >= 320 || y >= 240) return;
        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 240) ? 240 : y + h;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
                exp_q.push_back({CW'(xx * 2), CW'(yy * 2), DW'(col)});
    endtask

    task automatic scramble_inputs();
        rect_x = CW'($urandom_range(0, 2047));
        rect_y = CW'($urandom_range(0, 2047));
        rect_w = CW'($urandom_range(0, 2047));
        rect_h = CW'($urandom_range(0, 2047));
        color  = DW'($urandom_range(0, 255));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_cmd(input bit do_clear, input bit do_start, input int x, input int y,
                           input int w, input int h, input int col, input int inject);
        int n;
        logic [EW-1:0] e;
        if (do_clear) model(0, 0, 320, 240, 255);
        else model(x, y, w, h, col);
        n = exp_q.size();
        start  = do_start;
        clear  = do_clear;
        rect_x = CW'(x);
        rect_y = CW'(y);
        rect_w = CW'(w);
        rect_h = CW'(h);
        color  = DW'(col);
        @(negedge clock);
        start = 1'b0;
        clear = 1'b0;
        scramble_inputs();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check("pix", {31'd0, wr_en, busy, done, wr_x, wr_y, wr_data},
                  {31'd0, 3'b110, e});
            start = (i == inject);
            clear = (i == inject + 1);
            scramble_inputs();
            @(negedge clock);
        end
        start = 1'b0;
        clear = 1'b0;
        check("done", {61'd0, wr_en, busy, done}, 64'd1);
        @(negedge clock);
        check("idle", {61'd0, wr_en, busy, done}, 64'd0);
    endtask

    initial begin
        int x, y, w, h;
        repeat (2) @(negedge clock);
        check("rst_vals", {32'd0, wr_en, busy, done, state, wr_x, wr_y, wr_data}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst", {61'd0, wr_en, busy, done}, 64'd0);

        run_cmd(0, 1, 10, 5, 2, 2, 8'h3C, -5);
        run_cmd(0, 1, 318, 239, 5, 3, 8'hA5, -5);
        run_cmd(0, 1, 10, 10, 0, 5, 8'h11, -5);
        run_cmd(0, 1, 320, 10, 4, 4, 8'h22, -5);
        run_cmd(0, 1, 10, 10, 4, 0, 8'h33, -5);
        run_cmd(0, 1, 10, 240, 4, 4, 8'h44, -5);
        run_cmd(0, 1, 100, 100, 6, 3, 8'h5A, 4);
        run_cmd(0, 1, 0, 0, 320, 1, 8'h66, 300);
        run_cmd(1, 1, 5, 5, 3, 3, 8'h11, -5);

        for (int k = 0; k < 20; k++) begin
            x = $urandom_range(0, 330);
            y = $urandom_range(0, 250);
            w = $urandom_range(0, 14);
            h = $urandom_range(0, 14);
            run_cmd(0, 1, x, y, w, h, $urandom_range(0, 255), $urandom_range(0, 40));
        end

        // Async reset in the middle of a 4x4 fill
        start = 1'b1; rect_x = 11'd50; rect_y = 11'd60; rect_w = 11'd4; rect_h = 11'd4;
        color = 8'h77;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ar_pix", {34'd0, wr_en, wr_x, wr_y, wr_data},
                  {34'd0, 1'b1, CW'(100 + 2 * i), CW'(120), 8'h77});
            if (i < 2) @(negedge clock);
        end
        #2 reset = 1'b1;
        #1 check("ar_async", {32'd0, wr_en, busy, done, state, wr_x, wr_y, wr_data}, 64'd0);
        @(negedge clock);
        check("ar_hold", {61'd0, wr_en, busy, done}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("ar_nodone", {61'd0, wr_en, busy, done}, 64'd0);
        run_cmd(0, 1, 7, 9, 1, 1, 8'hC3, -5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
